// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file constants for the write-back path
//
// Purpose: constants shared by the register-file write-back arbiter and
// its sub-modules.
//   DATA_WIDTH    : register data width
//   ADDRESS_WIDTH : register address width
//   NUM_REGS      : number of architectural registers
//   REG_ZERO      : hard-wired zero register index
package rf_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int ADDRESS_WIDTH = 5;
  localparam int NUM_REGS      = 32;
  localparam int REG_ZERO      = 0;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant selection
//
// Purpose: picks the first asserted request scanning upward from ptr and
// wrapping modulo NUM_REQ. Holds no state; the pointer lives in the caller.
// Ports:
//   req         in  NUM_REQ  request vector
//   ptr         in  PTR_W    index of the highest-priority requester
//   grant       out NUM_REQ  one-hot grant, zero when nothing requests
//   grant_idx   out PTR_W    index of the granted requester (0 if none)
//   grant_valid out 1        some requester was granted
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_valid
);

  always_comb begin
    int idx;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - write-back arbiter and pending-write scoreboard
//
// Purpose: shares the register file's single write port among NUM_REQ
// write-back requesters with round-robin valid/ready arbitration, and
// tracks in-flight destinations so decode can stall on RAW hazards.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid / req_ready     per-requester handshake (ready one-hot or 0)
//   req_dest / req_data       packed per-requester destination and data
//   issue_valid / issue_dest  decode issues a write to issue_dest
//   issue_ready               issue accepted when high with issue_valid
//   rd_addr1 / rd_addr2       decode source addresses
//   rd1_pending / rd2_pending source has an outstanding write
//   rg_wrt_en/_dest/_data     registered register-file write port
module rf_wb_arbiter #(
  parameter int DATA_WIDTH    = rf_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = rf_pkg::ADDRESS_WIDTH,
  parameter int NUM_REGS      = rf_pkg::NUM_REGS,
  parameter int NUM_REQ       = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_dest,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic                            issue_valid,
  input  logic [ADDRESS_WIDTH-1:0]        issue_dest,
  output logic                            issue_ready,
  input  logic [ADDRESS_WIDTH-1:0]        rd_addr1,
  input  logic [ADDRESS_WIDTH-1:0]        rd_addr2,
  output logic                            rd1_pending,
  output logic                            rd2_pending,
  output logic                            rg_wrt_en,
  output logic [ADDRESS_WIDTH-1:0]        rg_wrt_dest,
  output logic [DATA_WIDTH-1:0]           rg_wrt_data
);

  import rf_pkg::*;

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR = ADDRESS_WIDTH'(REG_ZERO);

  logic [PTR_W-1:0]         rr_ptr;
  logic [NUM_REQ-1:0]       grant;
  logic [PTR_W-1:0]         grant_idx;
  logic                     grant_valid;
  logic                     grant_fire;
  logic [ADDRESS_WIDTH-1:0] sel_dest;
  logic [DATA_WIDTH-1:0]    sel_data;
  logic [NUM_REGS-1:0]      pending;
  logic [NUM_REGS-1:0]      pending_next;
  logic                     clr_issue;
  logic                     clr_rd1;
  logic                     clr_rd2;
  logic                     issue_fire;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req         (req_valid),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Nothing is accepted while reset is held.
  assign req_ready  = rst ? '0 : grant;
  assign grant_fire = grant_valid && !rst;

  assign sel_dest = req_dest[int'(grant_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  assign sel_data = req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

  // A write on the port this cycle retires its destination; the register
  // file captures on the negedge, so readers may treat it as already done.
  assign clr_issue = rg_wrt_en && (rg_wrt_dest == issue_dest);
  assign clr_rd1   = rg_wrt_en && (rg_wrt_dest == rd_addr1);
  assign clr_rd2   = rg_wrt_en && (rg_wrt_dest == rd_addr2);

  assign issue_ready = !rst && ((issue_dest == ZERO_ADDR) ||
                                !pending[issue_dest] || clr_issue);
  assign issue_fire  = issue_valid && issue_ready && (issue_dest != ZERO_ADDR);

  assign rd1_pending = !rst && pending[rd_addr1] && !clr_rd1;
  assign rd2_pending = !rst && pending[rd_addr2] && !clr_rd2;

  // Clear first, then set, so a same-cycle re-issue keeps the bit high.
  always_comb begin
    pending_next = pending;
    if (rg_wrt_en) begin
      pending_next[rg_wrt_dest] = 1'b0;
    end
    if (issue_fire) begin
      pending_next[issue_dest] = 1'b1;
    end
    pending_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_fire) begin
      rr_ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Writes to x0 are handshaken but never reach the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rg_wrt_en   <= 1'b0;
      rg_wrt_dest <= '0;
      rg_wrt_data <= '0;
    end else if (grant_fire && (sel_dest != ZERO_ADDR)) begin
      rg_wrt_en   <= 1'b1;
      rg_wrt_dest <= sel_dest;
      rg_wrt_data <= sel_data;
    end else begin
      rg_wrt_en   <= 1'b0;
      rg_wrt_dest <= '0;
      rg_wrt_data <= '0;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_dest;
  logic [95:0] req_data;
  logic        issue_valid;
  logic [4:0]  issue_dest;
  logic        issue_ready;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        rd1_pending;
  logic        rd2_pending;
  logic        rg_wrt_en;
  logic [4:0]  rg_wrt_dest;
  logic [31:0] rg_wrt_data;

  int total;
  int bad;

  rf_wb_arbiter #(
    .DATA_WIDTH    (32),
    .ADDRESS_WIDTH (5),
    .NUM_REGS      (32),
    .NUM_REQ       (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_dest    (req_dest),
    .req_data    (req_data),
    .issue_valid (issue_valid),
    .issue_dest  (issue_dest),
    .issue_ready (issue_ready),
    .rd_addr1    (rd_addr1),
    .rd_addr2    (rd_addr2),
    .rd1_pending (rd1_pending),
    .rd2_pending (rd2_pending),
    .rg_wrt_en   (rg_wrt_en),
    .rg_wrt_dest (rg_wrt_dest),
    .rg_wrt_data (rg_wrt_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] d, input logic [31:0] v);
    req_dest[i*5 +: 5]   = d;
    req_data[i*32 +: 32] = v;
  endtask

  // Advance past the next posedge; inputs change here, outputs settle by negedge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    req_valid   = 3'b111;
    req_dest    = '0;
    req_data    = '0;
    set_req(0, 5'd1, 32'hA);
    set_req(1, 5'd2, 32'hB);
    set_req(2, 5'd3, 32'hC);
    issue_valid = 1'b1;
    issue_dest  = 5'd5;
    rd_addr1    = 5'd5;
    rd_addr2    = 5'd5;

    // Reset held two cycles with every input active.
    cyc();
    cyc();
    smp();
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_issue_ready", 32'(issue_ready), 32'h0);
    check("rst_wrt_en", 32'(rg_wrt_en), 32'h0);
    check("rst_wrt_dest", 32'(rg_wrt_dest), 32'h0);
    check("rst_wrt_data", rg_wrt_data, 32'h0);
    check("rst_rd1_pending", 32'(rd1_pending), 32'h0);
    check("rst_rd2_pending", 32'(rd2_pending), 32'h0);
    cyc();
    rst         = 1'b0;
    issue_valid = 1'b0;

    // Round-robin with all three requesters valid.
    for (int k = 0; k < 6; k++) begin
      if (k > 0) cyc();
      smp();
      check($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(3'b001 << (k % 3)));
      if (k == 0) begin
        check("rr_en_0", 32'(rg_wrt_en), 32'h0);
      end else begin
        check($sformatf("rr_en_%0d", k), 32'(rg_wrt_en), 32'h1);
        check($sformatf("rr_dest_%0d", k), 32'(rg_wrt_dest), 32'(((k - 1) % 3) + 1));
        check($sformatf("rr_data_%0d", k), rg_wrt_data, 32'(32'hA + ((k - 1) % 3)));
      end
    end
    cyc();
    req_valid = 3'b000;
    smp();
    check("rr_tail_ready", 32'(req_ready), 32'h0);
    check("rr_tail_dest", 32'(rg_wrt_dest), 32'h3);
    cyc();
    smp();
    check("idle_en", 32'(rg_wrt_en), 32'h0);
    check("idle_dest", 32'(rg_wrt_dest), 32'h0);
    check("idle_data", rg_wrt_data, 32'h0);

    // Hazard: issue x5, pointer is back at 0.
    cyc();
    issue_valid = 1'b1;
    issue_dest  = 5'd5;
    smp();
    check("haz_issue_ready0", 32'(issue_ready), 32'h1);
    check("haz_rd1_c0", 32'(rd1_pending), 32'h0);
    cyc();
    issue_valid = 1'b0;
    smp();
    check("haz_rd1_c1", 32'(rd1_pending), 32'h1);
    check("haz_reissue_blocked", 32'(issue_ready), 32'h0);
    cyc();
    smp();
    check("haz_rd2_c2", 32'(rd2_pending), 32'h1);
    cyc();
    req_valid = 3'b010;
    set_req(1, 5'd5, 32'hDEADBEEF);
    smp();
    check("haz_grant1", 32'(req_ready), 32'h2);
    cyc();
    req_valid   = 3'b000;
    issue_valid = 1'b1;
    smp();
    check("haz_wb_en", 32'(rg_wrt_en), 32'h1);
    check("haz_wb_dest", 32'(rg_wrt_dest), 32'h5);
    check("haz_wb_data", rg_wrt_data, 32'hDEADBEEF);
    check("haz_bypass_rd1", 32'(rd1_pending), 32'h0);
    check("haz_reissue_ok", 32'(issue_ready), 32'h1);
    // Re-issue accepted in the write cycle keeps x5 pending; second write
    // comes from requester 1 while the pointer sits at 2.
    cyc();
    issue_valid = 1'b0;
    req_valid   = 3'b010;
    set_req(1, 5'd5, 32'h55);
    smp();
    check("reissue_rd1", 32'(rd1_pending), 32'h1);
    check("reissue_en", 32'(rg_wrt_en), 32'h0);
    check("wrap_grant1", 32'(req_ready), 32'h2);
    cyc();
    req_valid = 3'b000;
    smp();
    check("wb2_dest", 32'(rg_wrt_dest), 32'h5);
    check("wb2_bypass_rd2", 32'(rd2_pending), 32'h0);
    cyc();
    smp();
    check("cleared_rd1", 32'(rd1_pending), 32'h0);
    check("cleared_rd2", 32'(rd2_pending), 32'h0);

    // x0 write from requester 2 (pointer at 2), plus x0 issue/read.
    cyc();
    req_valid   = 3'b100;
    set_req(2, 5'd0, 32'h77);
    issue_valid = 1'b1;
    issue_dest  = 5'd0;
    rd_addr1    = 5'd0;
    smp();
    check("x0_ready", 32'(req_ready), 32'h4);
    check("x0_issue_ready", 32'(issue_ready), 32'h1);
    check("x0_rd1", 32'(rd1_pending), 32'h0);
    cyc();
    issue_valid = 1'b0;
    req_valid   = 3'b111;
    set_req(0, 5'd1, 32'hA);
    set_req(1, 5'd2, 32'hB);
    set_req(2, 5'd3, 32'hC);
    issue_valid = 1'b1;
    issue_dest  = 5'd7;
    rd_addr2    = 5'd7;
    smp();
    check("x0_wrt_en", 32'(rg_wrt_en), 32'h0);
    check("x0_wrt_data", rg_wrt_data, 32'h0);
    check("x0_ptr_wrap", 32'(req_ready), 32'h1);
    check("x7_issue_ready", 32'(issue_ready), 32'h1);

    // Reset mid-operation: grant to 0 and x7 issued above, reset next cycle.
    cyc();
    issue_valid = 1'b0;
    rst         = 1'b1;
    smp();
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    check("mid_rst_issue_ready", 32'(issue_ready), 32'h0);
    check("mid_rst_en_prev", 32'(rg_wrt_en), 32'h1);
    cyc();
    rst       = 1'b0;
    req_valid = 3'b000;
    smp();
    check("mid_rst_en", 32'(rg_wrt_en), 32'h0);
    check("mid_rst_pending7", 32'(rd2_pending), 32'h0);
    req_valid = 3'b110;
    #1;
    check("mid_rst_ptr_110", 32'(req_ready), 32'h2);
    req_valid = 3'b111;
    #1;
    check("mid_rst_ptr_111", 32'(req_ready), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
